// File: rtl/vrf_pkg.sv
// Shared types and width helpers for the banked vector register file.
// The bypass forwarding path in vrf_banked is enabled with the VRF_BYPASS_EN macro.
package vrf_pkg;

  localparam int unsigned DFLT_REG_NUM = 32;
  localparam int unsigned DFLT_LANES   = 4;

  localparam int unsigned ADDR_B = $clog2(DFLT_REG_NUM);
  localparam int unsigned ELEM_B = $clog2(DFLT_LANES);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_CAP  = 1'b1
  } rd_state_t;

  // Index width that stays at least one bit wide for single-entry arrays.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vrf_bank.sv
// One behavioural 1R1W storage bank: synchronous write, registered read with enable.
module vrf_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register have no reset so they map onto RAM
  // macros; a same-edge write is not visible to the read (read-first).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vrf_banked.sv
// Banked vector register file with a sequential operand-collection read port.
// Define VRF_BYPASS_EN to forward a write that lands on a read's issue cycle.
module vrf_banked
  import vrf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_NUM    = DFLT_REG_NUM,
  parameter int unsigned LANES      = DFLT_LANES,
  parameter int unsigned RD_PORTS   = 3,
  localparam int unsigned AW = $clog2(REG_NUM),
  localparam int unsigned EW = $clog2(LANES),
  localparam int unsigned NW = $clog2(RD_PORTS + 1)
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  input  logic                           rd_req_i,
  input  logic [NW-1:0]                  rd_num_i,
  input  logic [RD_PORTS*AW-1:0]         rd_addr_i,
  input  logic [EW-1:0]                  rd_elem_i,
  output logic                           rd_ready_o,
  output logic                           rd_valid_o,
  output logic [RD_PORTS*DATA_WIDTH-1:0] op_rdata_o,
  input  logic                           wr_valid_i,
  input  logic [AW-1:0]                  wr_addr_i,
  input  logic [EW-1:0]                  wr_elem_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  output logic [DATA_WIDTH-1:0]          mask_rdata_o
);

  localparam int unsigned KW = idx_width(RD_PORTS);

  rd_state_t             state_q, state_d;
  logic [KW-1:0]         k_q, k_d, k_inc;
  logic [NW-1:0]         n_q, n_d, num_clamped;
  logic                  valid_q, valid_d;
  logic [AW-1:0]         addr_q [RD_PORTS];
  logic [AW-1:0]         addr_d [RD_PORTS];
  logic                  more_ops;
  logic                  capture;
  logic                  bank_re;
  logic [AW-1:0]         bank_raddr;
  logic [DATA_WIDTH-1:0] bank_rdata [LANES];
  logic [DATA_WIDTH-1:0] opnd_q [RD_PORTS][LANES];
  logic [DATA_WIDTH-1:0] mask_q;

  // All banks share the read address; each bank owns one element lane.
  for (genvar l = 0; l < LANES; l++) begin : g_bank
    vrf_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (REG_NUM),
      .ADDR_W    (AW)
    ) u_bank (
      .clk_i  (clk_i),
      .we_i   (wr_valid_i && (wr_elem_i == EW'(l))),
      .waddr_i(wr_addr_i),
      .wdata_i(wdata_i),
      .re_i   (bank_re),
      .raddr_i(bank_raddr),
      .rdata_o(bank_rdata[l])
    );
  end

  always_comb begin
    num_clamped = rd_num_i;
    if (rd_num_i == '0) begin
      num_clamped = NW'(1);
    end else if (32'(rd_num_i) > RD_PORTS) begin
      num_clamped = NW'(RD_PORTS);
    end
  end

  assign k_inc    = k_q + KW'(1);
  assign more_ops = (32'(k_q) + 32'd1) < 32'(n_q);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    bank_re    = 1'b0;
    bank_raddr = '0;
    capture    = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (rd_req_i) begin
          for (int i = 0; i < RD_PORTS; i++) begin
            addr_d[i] = rd_addr_i[i*AW +: AW];
          end
          n_d        = num_clamped;
          k_d        = '0;
          valid_d    = 1'b0;
          bank_re    = 1'b1;
          bank_raddr = rd_addr_i[AW-1:0];
          state_d    = RD_CAP;
        end
      end
      RD_CAP: begin
        capture = 1'b1;
        if (more_ops) begin
          bank_re    = 1'b1;
          bank_raddr = addr_q[k_inc];
          k_d        = k_inc;
        end else begin
          valid_d = 1'b1;
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

`ifdef VRF_BYPASS_EN
  logic                  byp_hit_q;
  logic [EW-1:0]         byp_lane_q;
  logic [DATA_WIDTH-1:0] byp_data_q;
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= RD_IDLE;
      k_q     <= '0;
      n_q     <= NW'(1);
      valid_q <= 1'b0;
      mask_q  <= '0;
      for (int i = 0; i < RD_PORTS; i++) begin
        addr_q[i] <= '0;
        for (int l = 0; l < LANES; l++) begin
          opnd_q[i][l] <= '0;
        end
      end
`ifdef VRF_BYPASS_EN
      byp_hit_q  <= 1'b0;
      byp_lane_q <= '0;
      byp_data_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      if (capture) begin
        for (int i = 0; i < RD_PORTS; i++) begin
          if (k_q == KW'(i)) begin
            for (int l = 0; l < LANES; l++) begin
              opnd_q[i][l] <= bank_rdata[l];
            end
`ifdef VRF_BYPASS_EN
            // The bank returned pre-write data; patch in the issue-cycle write.
            if (byp_hit_q) begin
              opnd_q[i][byp_lane_q] <= byp_data_q;
            end
`endif
          end
        end
      end
`ifdef VRF_BYPASS_EN
      byp_hit_q  <= bank_re && wr_valid_i && (wr_addr_i == bank_raddr);
      byp_lane_q <= wr_elem_i;
      byp_data_q <= wdata_i;
`endif
      if (wr_valid_i && (wr_addr_i == '0) && (wr_elem_i == '0)) begin
        mask_q <= wdata_i;
      end
    end
  end

  always_comb begin
    op_rdata_o = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      op_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = opnd_q[i][rd_elem_i];
    end
  end

  assign rd_ready_o   = (state_q == RD_IDLE);
  assign rd_valid_o   = valid_q;
  assign mask_rdata_o = mask_q;

endmodule

// File: tb/tb_vrf_banked.sv
// Directed self-checking bench for vrf_banked (LANES=4, DATA_WIDTH=32, REG_NUM=32, RD_PORTS=3).
module tb_vrf_banked;
  import vrf_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  rd_req;
  logic [1:0]            rd_num;
  logic [3*ADDR_B-1:0]   rd_addr;
  logic [ELEM_B-1:0]     rd_elem;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [95:0]           op_rdata;
  logic                  wr_valid;
  logic [ADDR_B-1:0]     wr_addr;
  logic [ELEM_B-1:0]     wr_elem;
  logic [31:0]           wdata;
  logic [31:0]           mask_rdata;

  int checks = 0;
  int errors = 0;

  vrf_banked dut (
    .clk_i       (clk),
    .resetn_i    (rst_n),
    .rd_req_i    (rd_req),
    .rd_num_i    (rd_num),
    .rd_addr_i   (rd_addr),
    .rd_elem_i   (rd_elem),
    .rd_ready_o  (rd_ready),
    .rd_valid_o  (rd_valid),
    .op_rdata_o  (op_rdata),
    .wr_valid_i  (wr_valid),
    .wr_addr_i   (wr_addr),
    .wr_elem_i   (wr_elem),
    .wdata_i     (wdata),
    .mask_rdata_o(mask_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3*ADDR_B-1:0] pack(input logic [ADDR_B-1:0] a0,
                                               input logic [ADDR_B-1:0] a1,
                                               input logic [ADDR_B-1:0] a2);
    return {a2, a1, a0};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rd_req   = 1'b0;
    rd_num   = 2'd1;
    rd_addr  = '0;
    rd_elem  = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_elem  = '0;
    wdata    = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", 128'(rd_ready), 128'(1));
    check("rst_valid", 128'(rd_valid), 128'(0));
    check("rst_op",    128'(op_rdata), 128'(0));
    check("rst_mask",  128'(mask_rdata), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Fill registers 5/6/7 with 0xA0+e / 0xB0+e / 0xC0+e
    for (int r = 5; r <= 7; r++) begin
      for (int e = 0; e < 4; e++) begin
        wr_valid = 1'b1;
        wr_addr  = 5'(r);
        wr_elem  = 2'(e);
        wdata    = 32'h90 + 32'h10 * 32'(r - 4) + 32'(e);
        tick();
      end
    end
    wr_valid = 1'b0;

    // Three-operand read of {7,6,5}
    rd_num  = 2'd3;
    rd_addr = pack(5'd5, 5'd6, 5'd7);
    rd_elem = 2'd2;
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    check("r3_busy_ready", 128'(rd_ready), 128'(0));
    check("r3_c0_valid",   128'(rd_valid), 128'(0));
    tick();
    tick();
    check("r3_c2_valid", 128'(rd_valid), 128'(0));
    tick();
    check("r3_c3_valid", 128'(rd_valid), 128'(1));
    check("r3_c3_ready", 128'(rd_ready), 128'(1));
    check("r3_elem2",    128'(op_rdata), 128'({32'hC2, 32'hB2, 32'hA2}));
    rd_elem = 2'd0;
    #1;
    check("r3_elem0",    128'(op_rdata), 128'({32'hC0, 32'hB0, 32'hA0}));

    // Two-operand read with request held high: back-to-back acceptance
    rd_num  = 2'd2;
    rd_addr = pack(5'd7, 5'd6, 5'd5);
    rd_elem = 2'd1;
    rd_req  = 1'b1;
    tick();
    check("r2_busy_ready", 128'(rd_ready), 128'(0));
    tick();
    check("r2_c1_valid", 128'(rd_valid), 128'(0));
    rd_addr = pack(5'd6, 5'd7, 5'd5);
    tick();
    check("r2_c2_valid", 128'(rd_valid), 128'(1));
    check("r2_c2_ready", 128'(rd_ready), 128'(1));
    check("r2_slots",    128'(op_rdata), 128'({32'hC1, 32'hB1, 32'hC1}));
    tick();
    check("b2b_accept_ready", 128'(rd_ready), 128'(0));
    check("b2b_accept_valid", 128'(rd_valid), 128'(0));
    rd_req  = 1'b0;
    rd_addr = pack(5'd0, 5'd0, 5'd0);
    tick();
    tick();
    check("b2b_valid", 128'(rd_valid), 128'(1));
    check("b2b_slots", 128'(op_rdata), 128'({32'hC1, 32'hC1, 32'hB1}));

    // Write to reg 5 elem 1 on the issue cycle of a read of reg 5
    rd_num   = 2'd1;
    rd_addr  = pack(5'd5, 5'd0, 5'd0);
    rd_elem  = 2'd1;
    rd_req   = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 5'd5;
    wr_elem  = 2'd1;
    wdata    = 32'hDEAD;
    tick();
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    check("fwd_c0_valid", 128'(rd_valid), 128'(0));
    tick();
    check("fwd_c1_valid", 128'(rd_valid), 128'(1));
`ifdef VRF_BYPASS_EN
    check("fwd_slot0", 128'(op_rdata[31:0]), 128'(32'hDEAD));
`else
    check("fwd_slot0", 128'(op_rdata[31:0]), 128'(32'hA1));
`endif
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    check("reread_slot0", 128'(op_rdata[31:0]), 128'(32'hDEAD));

    // Reset in cycle 1 of a three-operand read
    rd_num  = 2'd3;
    rd_addr = pack(5'd5, 5'd6, 5'd7);
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 128'(rd_ready), 128'(1));
    check("midrst_valid", 128'(rd_valid), 128'(0));
    check("midrst_op_e1", 128'(op_rdata), 128'(0));
    rd_elem = 2'd3;
    #1;
    check("midrst_op_e3", 128'(op_rdata), 128'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    check("postrst_c2_valid", 128'(rd_valid), 128'(0));
    tick();
    check("postrst_c3_valid", 128'(rd_valid), 128'(1));
    check("postrst_slots",    128'(op_rdata), 128'({32'hC3, 32'hB3, 32'hA3}));

    // Mask shadow of register 0, element 0
    wr_valid = 1'b1;
    wr_addr  = 5'd0;
    wr_elem  = 2'd0;
    wdata    = 32'h0000_000F;
    tick();
    check("mask_write", 128'(mask_rdata), 128'(32'hF));
    wr_elem = 2'd1;
    wdata   = 32'h1234_5678;
    tick();
    check("mask_other_elem", 128'(mask_rdata), 128'(32'hF));
    wr_addr = 5'd1;
    wr_elem = 2'd0;
    wdata   = 32'h0000_0077;
    tick();
    wr_valid = 1'b0;
    check("mask_other_reg", 128'(mask_rdata), 128'(32'hF));

    // rd_num = 0 behaves as a single-operand read
    rd_num  = 2'd0;
    rd_addr = pack(5'd6, 5'd0, 5'd0);
    rd_elem = 2'd0;
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    check("num0_c0_valid", 128'(rd_valid), 128'(0));
    check("num0_c0_ready", 128'(rd_ready), 128'(0));
    tick();
    check("num0_c1_valid", 128'(rd_valid), 128'(1));
    check("num0_c1_ready", 128'(rd_ready), 128'(1));
    check("num0_slots",    128'(op_rdata), 128'({32'hC0, 32'hB0, 32'hB0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
